// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Scans digits 0..3, blanks the start of each slot to hide ghosting,
// takes a coherent snapshot of the display inputs once per frame, and
// applies a free-running blink to selected digits.
module seg7_scan_driver #(
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 50000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] seg_data,
   input  logic [3:0]  dp_data,
   input  logic [3:0]  blink_mask,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PHASE_MAX = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   logic [PW-1:0]       phase_cnt;
   logic [1:0]          digit_idx;
   logic [BW-1:0]       blink_cnt;
   logic                blink_phase;
   logic [3:0][4:0]     snap_codes;
   logic [3:0]          snap_dp;
   logic [3:0]          snap_mask;
   logic [3:0]          an_nxt;
   logic [6:0]          seg_nxt;
   logic                dp_nxt;
   logic                frame_start;

   // Character decode, active-high gfedcba; unknown codes are blank.
   function automatic logic [6:0] decode(input logic [4:0] code);
      case (code)
         5'd0:    decode = 7'h3F;
         5'd1:    decode = 7'h06;
         5'd2:    decode = 7'h5B;
         5'd3:    decode = 7'h4F;
         5'd4:    decode = 7'h66;
         5'd5:    decode = 7'h6D;
         5'd6:    decode = 7'h7D;
         5'd7:    decode = 7'h07;
         5'd8:    decode = 7'h7F;
         5'd9:    decode = 7'h6F;
         5'd10:   decode = 7'h40;
         5'd15:   decode = 7'h3E;
         5'd16:   decode = 7'h73;
         5'd17:   decode = 7'h5C;
         5'd19:   decode = 7'h5E;
         5'd20:   decode = 7'h54;
         default: decode = 7'h00;
      endcase
   endfunction

   assign frame_start = (digit_idx == 2'd0) && (phase_cnt == '0);

   // Slot phase counter and digit index; digit advances on each phase wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_cnt <= '0;
         digit_idx <= 2'd0;
      end else if (phase_cnt == PHASE_MAX) begin
         phase_cnt <= '0;
         digit_idx <= digit_idx + 2'd1;
      end else begin
         phase_cnt <= phase_cnt + 1'b1;
      end
   end

   // Free-running blink timebase, unrelated to the scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_MAX) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

   // Frame snapshot: inputs are only seen here, so a frame is always coherent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_codes <= {4{5'd31}};
         snap_dp    <= 4'b0000;
         snap_mask  <= 4'b0000;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_start;
         if (frame_start) begin
            snap_codes <= seg_data;
            snap_dp    <= dp_data;
            snap_mask  <= blink_mask;
         end
      end
   end

   // Next output pattern: dark during the blanking window, else the
   // selected digit; blink kills cathodes but keeps the anode driven.
   always_comb begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
      dp_nxt  = 1'b1;
      if (phase_cnt >= BLANK_END) begin
         an_nxt[digit_idx] = 1'b0;
         if (!(blink_phase && snap_mask[digit_idx])) begin
            seg_nxt = ~decode(snap_codes[digit_idx]);
            dp_nxt  = ~snap_dp[digit_idx];
         end
      end
   end

   // Registered pins; async reset forces the display dark at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= dp_nxt;
      end
   end

endmodule
